// File: rtl/vga_sync_gen.sv
// 640x480@60 sync generator on the 100 MHz master clock, stepped by pixel enables.
// Build option: define VGA_DCLK_INTERNAL_EN to ignore dclk and use an internal /4 phase counter.
module vga_sync_gen #(
  parameter logic [9:0] HPIXELS = 10'd800,
  parameter logic [9:0] VLINES  = 10'd521,
  parameter logic [9:0] HPULSE  = 10'd96,
  parameter logic [9:0] VPULSE  = 10'd2,
  parameter logic [9:0] HBP     = 10'd144,
  parameter logic [9:0] HFP     = 10'd784,
  parameter logic [9:0] VBP     = 10'd31,
  parameter logic [9:0] VFP     = 10'd511
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       dclk,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_en,
  output logic       frame_tick
);

  logic       pix_en_s;
  logic       line_end_s;
  logic       frame_end_s;
  logic       video_on_s;
  logic [9:0] hc_r;
  logic [9:0] vc_r;
  logic       frame_tick_r;

`ifdef VGA_DCLK_INTERNAL_EN
  logic [1:0] phase_r;
  logic       unused_dclk_s;

  assign unused_dclk_s = dclk;

  // Free-running /4 phase counter replacing the external pixel clock.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      phase_r <= 2'b00;
    end else begin
      phase_r <= phase_r + 2'b01;
    end
  end

  assign pix_en_s = (phase_r == 2'b11);
`else
  logic dclk_q_r;

  // dclk is only ever data here; keep last sample for rising-edge detection.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dclk_q_r <= 1'b0;
    end else begin
      dclk_q_r <= dclk;
    end
  end

  assign pix_en_s = dclk & ~dclk_q_r;
`endif

  assign line_end_s  = (hc_r == (HPIXELS - 10'd1));
  assign frame_end_s = line_end_s && (vc_r == (VLINES - 10'd1));

  // Horizontal/vertical position counters, advanced once per pixel enable.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hc_r <= 10'd0;
      vc_r <= 10'd0;
    end else if (pix_en_s) begin
      if (line_end_s) begin
        hc_r <= 10'd0;
        if (vc_r == (VLINES - 10'd1)) begin
          vc_r <= 10'd0;
        end else begin
          vc_r <= vc_r + 10'd1;
        end
      end else begin
        hc_r <= hc_r + 10'd1;
        vc_r <= vc_r;
      end
    end else begin
      hc_r <= hc_r;
      vc_r <= vc_r;
    end
  end

  // One-clock pulse following the enable that finishes the last line.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= pix_en_s && frame_end_s;
    end
  end

  // Sync, visible-window and coordinate decode from the counters.
  always_comb begin
    hsync      = 1'b0;
    vsync      = 1'b0;
    video_on_s = 1'b0;
    pix_x      = 10'd0;
    pix_y      = 10'd0;
    hsync      = ~(hc_r < HPULSE);
    vsync      = ~(vc_r < VPULSE);
    video_on_s = (hc_r >= HBP) && (hc_r < HFP) && (vc_r >= VBP) && (vc_r < VFP);
    if (video_on_s) begin
      pix_x = hc_r - HBP;
      pix_y = vc_r - VBP;
    end else begin
      pix_x = 10'd0;
      pix_y = 10'd0;
    end
  end

  assign video_on   = video_on_s;
  assign pix_en     = pix_en_s;
  assign frame_tick = frame_tick_r;

endmodule
